// File: rtl/ti_s4_pkg.sv
// Shared constants and share-slicing helper for the threshold-implemented 4-bit S-box.
package ti_s4_pkg;

  localparam int NSHARE  = 3;
  localparam int WIDTH   = 4;
  localparam int SHARE_W = WIDTH;
  localparam int VEC_W   = NSHARE * SHARE_W;

  // Extract share j from a packed share vector (share j lives at [j*WIDTH +: WIDTH]).
  function automatic logic [SHARE_W-1:0] get_share(input logic [VEC_W-1:0] vec, input int j);
    return vec[j*SHARE_W +: SHARE_W];
  endfunction

endpackage

// File: rtl/ti_ring_refresh.sv
// Sum-preserving ring refresh: share j picks up r_j and r_(j+1 mod N), so each r
// is XORed into exactly two shares and the XOR over all shares is unchanged.
module ti_ring_refresh #(
  parameter int NSHARE = ti_s4_pkg::NSHARE,
  parameter int WIDTH  = ti_s4_pkg::WIDTH
) (
  input  logic [NSHARE*WIDTH-1:0] shares,
  input  logic [NSHARE*WIDTH-1:0] rnd,
  output logic [NSHARE*WIDTH-1:0] refreshed
);

  // Each share is only ever combined with randomness, never with another share.
  for (genvar j = 0; j < NSHARE; j++) begin : g_share
    localparam int JN = (j + 1) % NSHARE;
    assign refreshed[j*WIDTH +: WIDTH] = shares[j*WIDTH +: WIDTH]
                                       ^ rnd[j*WIDTH +: WIDTH]
                                       ^ rnd[JN*WIDTH +: WIDTH];
  end

endmodule

// File: rtl/ti_s4_share_reg.sv
// Inter-stage share register between round-1 and round-2 component functions.
// Two-entry skid buffer; round 2 sees shares straight from the head register.
//
// Handshake: a transfer happens on a side in any cycle where valid and ready are
// both high at the rising edge; valid, once raised, holds together with its data
// until accepted; in_ready depends only on reset and occupancy, never on
// in_valid or out_ready. On the input side a refresh-enabled block additionally
// needs rnd_valid, otherwise the offer is a starvation stall.
module ti_s4_share_reg #(
  parameter int NSHARE  = ti_s4_pkg::NSHARE,
  parameter int WIDTH   = ti_s4_pkg::WIDTH,
  parameter bit REFRESH = 1'b1,
  parameter int CNT_W   = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [NSHARE*WIDTH-1:0] in_shares,
  input  logic [NSHARE*WIDTH-1:0] rnd,
  input  logic                    rnd_valid,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [NSHARE*WIDTH-1:0] out_shares,
  output logic [CNT_W-1:0]        ops_cnt,
  output logic [CNT_W-1:0]        starve_cnt,
  output logic [1:0]              dbg_state
);

  localparam int VW = NSHARE * WIDTH;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_t;

  occ_t          state_q, state_d;
  logic [VW-1:0] head_q, tail_q;
  logic [VW-1:0] fresh;
  logic          push, pop, stall;

  if (REFRESH) begin : g_refresh
    ti_ring_refresh #(.NSHARE(NSHARE), .WIDTH(WIDTH)) u_refresh (
      .shares    (in_shares),
      .rnd       (rnd),
      .refreshed (fresh)
    );
    assign push  = in_valid & in_ready & rnd_valid;
    assign stall = in_valid & in_ready & ~rnd_valid;
  end else begin : g_pass
    assign fresh = in_shares;
    assign push  = in_valid & in_ready;
    assign stall = 1'b0;
  end

  assign pop        = out_valid & out_ready;
  assign out_shares = head_q;
  assign dbg_state  = state_q;

  // Occupancy state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= OCC_EMPTY;
    else     state_q <= state_d;
  end

  // Occupancy next-state: push/pop combinations per state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      OCC_EMPTY: if (push) state_d = OCC_ONE;
      OCC_ONE: begin
        if (push && !pop)      state_d = OCC_FULL;
        else if (pop && !push) state_d = OCC_EMPTY;
      end
      OCC_FULL:  if (pop) state_d = OCC_ONE;
      default:   state_d = OCC_EMPTY;
    endcase
  end

  // Handshake outputs from registered occupancy; in_ready also held low in reset.
  always_comb begin
    in_ready  = !rst && (state_q != OCC_FULL);
    out_valid = (state_q != OCC_EMPTY);
  end

  // Entry storage: head feeds round 2 directly, tail is the skid slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      case (state_q)
        OCC_EMPTY: if (push) head_q <= fresh;
        OCC_ONE: begin
          if (push && pop) head_q <= fresh;
          else if (push)   tail_q <= fresh;
        end
        OCC_FULL:  if (pop) head_q <= tail_q;
        default: ;
      endcase
    end
  end

  // Accepted-transfer and randomness-starvation counters, both free-running wraps.
  always_ff @(posedge clk) begin
    if (rst) begin
      ops_cnt    <= '0;
      starve_cnt <= '0;
    end else begin
      if (push)  ops_cnt    <= ops_cnt + 1'b1;
      if (stall) starve_cnt <= starve_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_ti_s4_share_reg.sv
// Bench for ti_s4_share_reg: directed scenarios plus randomized traffic, with a
// queue-based reference model and a decoupled output monitor.
module tb_ti_s4_share_reg;
  import ti_s4_pkg::*;

  localparam int N  = 3;
  localparam int W  = 4;
  localparam int VW = N * W;
  localparam int CW = 16;
  localparam bit REF_EN = 1'b1;

  logic          clk, rst;
  logic          in_valid, in_ready, rnd_valid, out_valid, out_ready;
  logic [VW-1:0] in_shares, rnd, out_shares;
  logic [CW-1:0] ops_cnt, starve_cnt;
  logic [1:0]    dbg_state;

  ti_s4_share_reg #(.NSHARE(N), .WIDTH(W), .REFRESH(REF_EN), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_shares(in_shares),
    .rnd(rnd), .rnd_valid(rnd_valid),
    .out_valid(out_valid), .out_ready(out_ready), .out_shares(out_shares),
    .ops_cnt(ops_cnt), .starve_cnt(starve_cnt), .dbg_state(dbg_state)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard state
  logic [VW-1:0] exp_q[$];
  logic [CW-1:0] ops_exp, starve_exp;
  int            tests, fails;
  bit            started;
  bit            prev_hold;
  logic [VW-1:0] prev_data;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: each stored share is s_j ^ r_j ^ r_(j+1 mod N).
  function automatic logic [VW-1:0] model_refresh(input logic [VW-1:0] s, input logic [VW-1:0] r);
    logic [W-1:0]  sa[N];
    logic [W-1:0]  ra[N];
    logic [VW-1:0] res;
    for (int j = 0; j < N; j++) begin
      sa[j] = get_share(s, j);
      ra[j] = get_share(r, j);
    end
    res = '0;
    for (int j = 0; j < N; j++)
      res[j*W +: W] = REF_EN ? (sa[j] ^ ra[j] ^ ra[(j+1) % N]) : sa[j];
    return res;
  endfunction

  function automatic logic [W-1:0] unshare(input logic [VW-1:0] v);
    logic [W-1:0] x;
    x = '0;
    for (int j = 0; j < N; j++) x ^= get_share(v, j);
    return x;
  endfunction

  // Stimulus capture: predicts handshakes, counters and occupancy for the next edge.
  always @(negedge clk) begin
    bit ir_exp;
    if (started) begin
      ir_exp = !rst && (exp_q.size() < 2);
      check("in_ready", 32'(in_ready), 32'(ir_exp));
      check("out_valid", 32'(out_valid), 32'(exp_q.size() > 0));
      check("ops_cnt", 32'(ops_cnt), 32'(ops_exp));
      check("starve_cnt", 32'(starve_cnt), 32'(starve_exp));
      if (rst) begin
        exp_q.delete();
        ops_exp    = '0;
        starve_exp = '0;
      end else if (in_valid && ir_exp) begin
        if (rnd_valid || !REF_EN) begin
          exp_q.push_back(model_refresh(in_shares, rnd));
          ops_exp = ops_exp + 1'b1;
        end else begin
          starve_exp = starve_exp + 1'b1;
        end
      end
    end
  end

  // Output monitor: pops the expected queue on each output transfer, checks holding.
  always @(negedge clk) begin
    logic [VW-1:0] e;
    #1;
    if (started && !rst) begin
      if (prev_hold) begin
        check("hold_valid", 32'(out_valid), 32'(1));
        check("hold_data", 32'(out_shares), 32'(prev_data));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL pop_empty: got %0h expected none at %0t", out_shares, $time);
        end else begin
          e = exp_q.pop_front();
          check("out_data", 32'(out_shares), 32'(e));
        end
      end
      prev_hold = out_valid && !out_ready;
      prev_data = out_shares;
    end else begin
      prev_hold = 1'b0;
    end
  end

  // Driver tasks
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic iv, input logic [VW-1:0] sh, input logic rv,
                       input logic [VW-1:0] r, input logic ordy);
    in_valid  = iv;
    in_shares = sh;
    rnd_valid = rv;
    rnd       = r;
    out_ready = ordy;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1'b0, '0, 1'b0, '0, 1'b0);
    cycle();
    check("rst_out_valid", 32'(out_valid), 32'(0));
    check("rst_out_shares", 32'(out_shares), 32'(0));
    check("rst_in_ready", 32'(in_ready), 32'(0));
    check("rst_ops", 32'(ops_cnt), 32'(0));
    check("rst_starve", 32'(starve_cnt), 32'(0));
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 32'(in_ready), 32'(1));
  endtask

  initial begin
    logic [VW-1:0] v;
    tests = 0; fails = 0; started = 0; prev_hold = 0; prev_data = '0;
    ops_exp = '0; starve_exp = '0;
    rst = 1'b1;
    drive(1'b0, '0, 1'b0, '0, 1'b0);
    cycle();
    started = 1;
    cycle();
    do_reset();

    // Single push, zero randomness: shares pass unchanged, latency 1.
    drive(1'b1, 12'h5A3, 1'b1, 12'h000, 1'b0);
    cycle();
    in_valid = 1'b0;
    check("t1_valid", 32'(out_valid), 32'(1));
    check("t1_data", 32'(out_shares), 32'h5A3);
    check("t1_ops", 32'(ops_cnt), 32'(1));
    out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;

    // Refresh with r0=1: share0 and share2 flip bit 0, unshared value stays C.
    drive(1'b1, 12'h5A3, 1'b1, 12'h001, 1'b0);
    cycle();
    in_valid = 1'b0;
    check("t2_data", 32'(out_shares), 32'h4A2);
    check("t2_xor", 32'(unshare(out_shares)), 32'hC);
    out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;

    // Back-pressure: three offers, two accepted, then ordered drain.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, VW'($urandom), 1'b1, VW'($urandom), 1'b0);
      #1;
      check("t3_in_ready", 32'(in_ready), 32'(i < 2));
      cycle();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      check("t3_drain_valid", 32'(out_valid), 32'(1));
      cycle();
    end
    check("t3_empty", 32'(out_valid), 32'(0));

    // Starvation: offers without randomness are stalls, not pushes.
    do_reset();
    drive(1'b1, 12'h123, 1'b0, '0, 1'b0);
    repeat (5) cycle();
    check("t4_starve", 32'(starve_cnt), 32'(5));
    check("t4_ops", 32'(ops_cnt), 32'(0));
    check("t4_valid", 32'(out_valid), 32'(0));
    rnd_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    check("t4_push_ops", 32'(ops_cnt), 32'(1));
    check("t4_push_valid", 32'(out_valid), 32'(1));
    out_ready = 1'b1;
    cycle();

    // Streaming: one transfer per cycle, occupancy stays at one.
    do_reset();
    for (int i = 0; i < 100; i++) begin
      drive(1'b1, VW'($urandom), 1'b1, VW'($urandom), 1'b1);
      cycle();
      check("t5_valid", 32'(out_valid), 32'(1));
      check("t5_state", 32'(dbg_state), 32'(1));
    end
    check("t5_ops", 32'(ops_cnt), 32'(100));
    in_valid = 1'b0;
    cycle();

    // Reset while full drops both entries.
    drive(1'b1, 12'hABC, 1'b1, VW'($urandom), 1'b0);
    cycle();
    in_shares = 12'h321;
    cycle();
    in_valid = 1'b0;
    check("t6_full_state", 32'(dbg_state), 32'(2));
    check("t6_full_ready", 32'(in_ready), 32'(0));
    do_reset();

    // Randomized traffic.
    for (int i = 0; i < 500; i++) begin
      drive(1'($urandom_range(0, 1)), VW'($urandom), 1'($urandom_range(0, 3) != 0),
            VW'($urandom), 1'($urandom_range(0, 2) != 0));
      cycle();
    end

    // Bounded drain.
    drive(1'b0, '0, 1'b0, '0, 1'b1);
    for (int i = 0; i < 10 && (exp_q.size() != 0 || out_valid); i++) cycle();
    cycle();
    check("drain_queue", 32'(exp_q.size()), 32'(0));
    check("drain_valid", 32'(out_valid), 32'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Safety net against a stuck run.
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
